// File: rtl/adder_core_pkg.sv
// Shared constants for the adder_core slice: default datapath width and the
// width of one carry-lookahead block.
package adder_core_pkg;
   localparam int WIDTH_DEFAULT = 32;
   localparam int CLA_BLK       = 4;
endpackage

// File: rtl/adder_core_if.sv
// Operand/result bundle for adder_core. The flag signals exist only when
// ADDER_FLAGS_EN is defined.
interface adder_core_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
`ifdef ADDER_FLAGS_EN
   logic             ovf;
   logic             zero;
   logic             ovf_q;
   logic             zero_q;
`endif

`ifdef ADDER_FLAGS_EN
   modport master (output a, b, input sum, cout, sum_q, cout_q, ovf, zero, ovf_q, zero_q);
   modport slave  (input a, b, output sum, cout, sum_q, cout_q, ovf, zero, ovf_q, zero_q);
`else
   modport master (output a, b, input sum, cout, sum_q, cout_q);
   modport slave  (input a, b, output sum, cout, sum_q, cout_q);
`endif
endinterface

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead slice: all internal carries come straight from the
// bit generate/propagate terms, and the group G/P are exported for chaining.
module adder_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       grp_g,
   output logic       grp_p,
   output logic       cout
);
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   always_comb begin
      p = a ^ b;
      g = a & b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
      cout  = grp_g | (grp_p & cin);
      s     = p ^ c;
   end
endmodule

// File: rtl/adder_core.sv
// WIDTH-bit adder built from chained 4-bit CLA slices, with a registered copy
// of the result. Define ADDER_FLAGS_EN to add signed-overflow and zero flags.
module adder_core
   import adder_core_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   adder_core_if.slave  bus
);
   localparam int NBLK = WIDTH / CLA_BLK;

   logic [NBLK:0]    carry;
   logic [NBLK-1:0]  g_blk;
   logic [NBLK-1:0]  p_blk;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             unused_gp;

   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < NBLK; gi++) begin : g_slice
         adder_cla4 u_cla4 (
            .a     (bus.a[gi*CLA_BLK +: CLA_BLK]),
            .b     (bus.b[gi*CLA_BLK +: CLA_BLK]),
            .cin   (carry[gi]),
            .s     (sum[gi*CLA_BLK +: CLA_BLK]),
            .grp_g (g_blk[gi]),
            .grp_p (p_blk[gi]),
            .cout  (carry[gi+1])
         );
      end
   endgenerate

   // Slices ripple on cout; the group terms are kept for a future second lookahead level.
   assign unused_gp = ^{g_blk, p_blk};
   assign cout      = carry[NBLK];

   logic [WIDTH-1:0] sum_d,  sum_q;
   logic             cout_d, cout_q;

   always_comb begin
      sum_d  = sum;
      cout_d = cout;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign bus.sum    = sum;
   assign bus.cout   = cout;
   assign bus.sum_q  = sum_q;
   assign bus.cout_q = cout_q;

`ifdef ADDER_FLAGS_EN
   logic ovf, zero;
   logic ovf_d, ovf_q;
   logic zero_d, zero_q;

   always_comb begin
      ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      zero   = (sum == '0);
      ovf_d  = ovf;
      zero_d = zero;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign bus.ovf    = ovf;
   assign bus.zero   = zero;
   assign bus.ovf_q  = ovf_q;
   assign bus.zero_q = zero_q;
`endif
endmodule

// File: tb/tb_adder_core.sv
// Self-checking bench for adder_core: directed corner cases, reset behaviour
// of the registered path and 200 random operand pairs against a 33-bit model.
module tb_adder_core;
   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   adder_core_if #(.WIDTH(32)) bus ();

   adder_core #(.WIDTH(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction: drive on the falling edge, check combinational outputs,
   // then check the registered copy just after the following rising edge.
   task automatic op(input logic [31:0] ai, input logic [31:0] bi, input logic rn, input string tag);
      logic [32:0] full;
      logic [31:0] exp_s;
      logic        exp_c;
      logic        exp_ovf;
      logic        exp_zero;
      @(negedge clk);
      bus.a = ai;
      bus.b = bi;
      rst_n = rn;
      #1;
      full     = {1'b0, ai} + {1'b0, bi};
      exp_s    = full[31:0];
      exp_c    = full[32];
      exp_ovf  = (ai[31] == bi[31]) && (exp_s[31] != ai[31]);
      exp_zero = (exp_s == 32'h0);
      chk({tag, ".sum"},  {1'b0, bus.sum},  {1'b0, exp_s});
      chk({tag, ".cout"}, {32'h0, bus.cout}, {32'h0, exp_c});
`ifdef ADDER_FLAGS_EN
      chk({tag, ".ovf"},  {32'h0, bus.ovf},  {32'h0, exp_ovf});
      chk({tag, ".zero"}, {32'h0, bus.zero}, {32'h0, exp_zero});
`endif
      @(posedge clk);
      #1;
      if (!rn) begin
         exp_s = 32'h0; exp_c = 1'b0; exp_ovf = 1'b0; exp_zero = 1'b0;
      end
      chk({tag, ".sum_q"},  {1'b0, bus.sum_q},  {1'b0, exp_s});
      chk({tag, ".cout_q"}, {32'h0, bus.cout_q}, {32'h0, exp_c});
`ifdef ADDER_FLAGS_EN
      chk({tag, ".ovf_q"},  {32'h0, bus.ovf_q},  {32'h0, exp_ovf});
      chk({tag, ".zero_q"}, {32'h0, bus.zero_q}, {32'h0, exp_zero});
`endif
      $display("txn %-10s rst_n=%0b a=%h b=%h sum=%h cout=%0b sum_q=%h cout_q=%0b",
               tag, rn, ai, bi, bus.sum, bus.cout, bus.sum_q, bus.cout_q);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      bus.a   = 32'h0;
      bus.b   = 32'h0;

      // Reset held for two edges; combinational path still tracks a,b.
      op(32'h0000_0005, 32'h0000_0007, 1'b0, "rst_1");
      op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "rst_2");

      // Release with a wrapping add, then reassert over a non-zero result.
      op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "rel_wrap");
      op(32'h0000_0010, 32'h0000_0020, 1'b1, "pre_rst");
      op(32'h0000_0010, 32'h0000_0020, 1'b0, "reassert");

      // Directed corners.
      op(32'h0000_0000, 32'h0000_0000, 1'b1, "zero");
      op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "ones_a");
      op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, "ones_b");
      op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "wrap");
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "max_max");
      op(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, "prop_1");
      op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, "alt");
      op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, "pos_ovf");
      op(32'h8000_0000, 32'h8000_0000, 1'b1, "neg_ovf");
      op(32'h0000_FFFF, 32'h0000_0001, 1'b1, "blk_carry");

`ifdef ADDER_FLAGS_EN
      @(negedge clk);
      bus.a = 32'h7FFF_FFFF; bus.b = 32'h0000_0001; #1;
      chk("flag_ovf1.ovf",  {32'h0, bus.ovf},  33'd1);
      chk("flag_ovf1.zero", {32'h0, bus.zero}, 33'd0);
      @(negedge clk);
      bus.a = 32'hFFFF_FFFF; bus.b = 32'h0000_0001; #1;
      chk("flag_zero.ovf",  {32'h0, bus.ovf},  33'd0);
      chk("flag_zero.zero", {32'h0, bus.zero}, 33'd1);
`endif

      // Random operands, occasionally with reset pulsed.
      for (int i = 0; i < 200; i++) begin
         op($urandom, $urandom, ($urandom_range(0, 15) != 0), $sformatf("rnd_%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
